clock_divider_ctrl: RTL and testbench
=====================================

// Module: clock_divider_ctrl
// PURPOSE
//  Programmable clock-enable/divided-clock generator; successor to the fixed divider feeding
//  the board display/ALU logic. Runtime-loadable divisor, free-run or one-shot mode, pause
//  control. Emits a single-cycle tick strobe and a 50%-duty toggle output (aclk).
//  Sits between the 100 MHz board clock and slow consumers (display scan, debouncers, ALU step).
// PARAMETERS
//  CNT_W        27          width of divisor and counter
//  DEFAULT_DIV  50_000_000  divisor loaded at reset (must fit CNT_W; 0 treated as 1)
// PORTS
//  clk        in   1      system clock; sole clock domain
//  rst        in   1      reset; synchronous, active-high
//  en         in   1      1 = count; 0 = pause (all state held)
//  mode       in   1      0 = free-run, 1 = one-shot
//  start      in   1      one-shot trigger (ignored in free-run or while busy)
//  div_load   in   1      load strobe for div_value
//  div_value  in   CNT_W  new divisor N; tick period = N clk cycles
//  tick       out  1      1-cycle strobe at each terminal count
//  aclk       out  1      toggles at each terminal count; period 2N
//  busy       out  1      high while in RUN or SHOT
//  count      out  CNT_W  current counter value
//  load_pend  out  1      divisor load pending (DIV_SYNC_LOAD_EN only; else tied 0)
// BEHAVIOUR
//  Reset (sync, highest priority, any state): state=IDLE, cnt=0, div_reg=DEFAULT_DIV
//   (clamped to 1 if 0), tick=0, aclk=0, busy=0, load_pend=0, pending divisor=0.
//  Divisor: div_value==0 loaded as 1. N=1 -> tick every cycle, aclk toggles every cycle.
//  Counter: 0..div_reg-1, increments by 1 each en cycle in RUN/SHOT. Terminal = cnt==div_reg-1.
//   At terminal edge: cnt<=0, tick<=1 (registered, high exactly one cycle), aclk<=~aclk.
//   First tick: N cycles after entering RUN/SHOT (cnt starts at 0).
//  en=0: cnt, aclk, state frozen; tick forced 0 that cycle; div_load still accepted.
//  FSM (all transitions gated by en=1):
//   IDLE: mode=0 -> RUN; mode=1 & start -> SHOT; cnt held at 0.
//   RUN : mode=1 -> IDLE, cnt<=0, aclk held, no tick that cycle. Terminal -> stay RUN.
//   SHOT: terminal -> tick, aclk toggles, -> IDLE. start ignored. mode change ignored until IDLE.
//  busy = (state!=IDLE); registered, updates same edge as state.
//  Load without macro: div_reg<=clamp(div_value) next edge, cnt<=0, aclk unchanged.
//   Load coincident with terminal: tick and aclk toggle still happen; new divisor applies.
//   Next tick then N_new cycles later.
//  rst mid-count, pending load, or SHOT: everything returns to reset values; no tick.
//  No wrap beyond div_reg-1; count never exceeds div_reg-1 (reload clears it).
// CONFIGURATION
//  Macro DIV_SYNC_LOAD_EN:
//   Defined: div_load captures value into pending reg, load_pend<=1. cnt not cleared.
//    Pending applied at next terminal edge, or next edge if IDLE; load_pend<=0 then.
//    Second load before apply overwrites pending (last wins). Load coincident with
//    terminal: applied on that edge.
//   Undefined: immediate load as above; load_pend constant 0; no pending register.
// TESTING (DEFAULT_DIV=4, CNT_W=8 unless noted)
//  1 rst=1 2 cycles, en=1 mode=0 -> tick every 4 cycles, aclk period 8, busy=1, count 0,1,2,3.
//  2 mode=1, start pulse -> busy 1, single tick 4 cycles later, busy 0, aclk toggled once;
//    start mid-SHOT ignored.
//  3 free-run, en=0 for 3 cycles at count=2 -> count holds 2, no tick; resumes,
//    tick 1 cycle after en=1 + count 3.
//  4 load div_value=0 -> ticks every cycle, aclk toggles every cycle; load 6 -> period 6.
//  5 no macro: load 2 at count=1 -> count 0 next edge, tick 2 cycles later.
//    Macro: load 2 at count=1 -> load_pend=1, tick at count=3, then period 2, load_pend=0.
//  6 rst asserted mid-SHOT at count=2 -> next edge all outputs 0, state IDLE, no tick emitted.

Source files
------------

// File: rtl/clock_divider_ctrl.sv
// ---------------------------------------------------------------------------
// clock_divider_ctrl
//   Programmable clock-enable / divided-clock generator. A runtime-loadable
//   divisor N sets the tick period (N clk cycles). The block can free-run or
//   fire a single terminal count (one-shot), and can be paused with i_en.
//   It emits a one-cycle tick strobe and a 50%-duty toggle output (period 2N).
//
// Optional feature macro: DIV_SYNC_LOAD_EN
//   Undefined (default): a divisor load takes effect on the next edge and
//                        clears the counter; o_load_pend is tied 0.
//   Defined:             a divisor load is parked in a pending register and
//                        applied at the next terminal count (or on the next
//                        edge while IDLE), so the running period is never cut.
//
// Ports
//   i_clk        in   1      system clock, sole clock domain
//   i_rst        in   1      synchronous active-high reset
//   i_en         in   1      1 = count, 0 = pause (state held, tick forced 0)
//   i_mode       in   1      0 = free-run, 1 = one-shot
//   i_start      in   1      one-shot trigger (ignored in free-run / while busy)
//   i_div_load   in   1      load strobe for i_div_value
//   i_div_value  in   CNT_W  new divisor (0 is treated as 1)
//   o_tick       out  1      one-cycle strobe at each terminal count
//   o_aclk       out  1      toggles at each terminal count
//   o_busy       out  1      high while in RUN or SHOT
//   o_count      out  CNT_W  current counter value
//   o_load_pend  out  1      divisor load waiting to be applied
// ---------------------------------------------------------------------------
module clock_divider_ctrl #(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_start,
  input  logic             i_div_load,
  input  logic [CNT_W-1:0] i_div_value,
  output logic             o_tick,
  output logic             o_aclk,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count,
  output logic             o_load_pend
);

  // A zero reset divisor would never reach a terminal count; clamp it to 1.
  localparam logic [CNT_W-1:0] DIV_RESET =
    (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SHOT = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_tick;
  logic             r_aclk;
  logic             r_busy;

  logic [CNT_W-1:0] w_div_new;
  logic             w_terminal;

  assign w_div_new  = (i_div_value == '0) ? CNT_W'(1) : i_div_value;
  assign w_terminal = (r_cnt == (r_div - CNT_W'(1)));

`ifdef DIV_SYNC_LOAD_EN
  logic [CNT_W-1:0] r_pend;
  logic             r_load_pend;
  logic             w_fire;

  // A terminal count is only acted on when counting actually happens this
  // edge; RUN with mode=1 exits to IDLE instead of ticking.
  assign w_fire = i_en && w_terminal &&
                  (((r_state == ST_RUN) && !i_mode) || (r_state == ST_SHOT));
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_div   <= DIV_RESET;
      r_tick  <= 1'b0;
      r_aclk  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef DIV_SYNC_LOAD_EN
      r_pend      <= '0;
      r_load_pend <= 1'b0;
`endif
    end else begin
      // Tick is a registered one-cycle strobe; it is only raised below.
      r_tick <= 1'b0;

      if (i_en) begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (!i_mode) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end else if (i_start) begin
              r_state <= ST_SHOT;
              r_busy  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (i_mode) begin
              // Leaving free-run wins over a coincident terminal: no tick.
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
            end else if (w_terminal) begin
              r_cnt  <= '0;
              r_tick <= 1'b1;
              r_aclk <= ~r_aclk;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_SHOT: begin
            if (w_terminal) begin
              r_cnt   <= '0;
              r_tick  <= 1'b1;
              r_aclk  <= ~r_aclk;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end
        endcase
      end

`ifdef DIV_SYNC_LOAD_EN
      // Deferred load: a load arriving on the terminal edge is applied
      // directly; otherwise it waits for the next terminal (or IDLE).
      if (w_fire && (i_div_load || r_load_pend)) begin
        r_div       <= i_div_load ? w_div_new : r_pend;
        r_load_pend <= 1'b0;
      end else if (i_div_load) begin
        r_pend      <= w_div_new;
        r_load_pend <= 1'b1;
      end else if ((r_state == ST_IDLE) && r_load_pend) begin
        r_div       <= r_pend;
        r_load_pend <= 1'b0;
      end
`else
      // Immediate load: restart the period from zero with the new divisor.
      // Placed after the FSM so it overrides any counter increment, while a
      // coincident tick/aclk toggle still goes through.
      if (i_div_load) begin
        r_div <= w_div_new;
        r_cnt <= '0;
      end
`endif
    end
  end

  assign o_tick  = r_tick;
  assign o_aclk  = r_aclk;
  assign o_busy  = r_busy;
  assign o_count = r_cnt;
`ifdef DIV_SYNC_LOAD_EN
  assign o_load_pend = r_load_pend;
`else
  assign o_load_pend = 1'b0;
`endif

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_divider_ctrl
//   Directed bench for clock_divider_ctrl (CNT_W=8, DEFAULT_DIV=4). Each step
//   pushes the expected post-edge outputs onto a scoreboard queue, advances
//   one clock edge, then pops the entry and checks every output against it.
// ---------------------------------------------------------------------------
module tb_clock_divider_ctrl;

  localparam int CNT_W = 8;

`ifdef DIV_SYNC_LOAD_EN
  localparam logic SYNC_LOAD = 1'b1;
`else
  localparam logic SYNC_LOAD = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic             mode;
  logic             start;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
  logic             tick;
  logic             aclk;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             load_pend;

  int n_checks = 0;
  int n_errors = 0;
  logic ea;

  typedef struct {
    logic             tick;
    logic             aclk;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             lp;
  } exp_t;

  exp_t sb_q[$];

  clock_divider_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_mode      (mode),
    .i_start     (start),
    .i_div_load  (div_load),
    .i_div_value (div_value),
    .o_tick      (tick),
    .o_aclk      (aclk),
    .o_busy      (busy),
    .o_count     (count),
    .o_load_pend (load_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string tag, input logic t, input logic a,
                      input logic b, input int c, input logic lp);
    exp_t e;
    e.tick = t;
    e.aclk = a;
    e.busy = b;
    e.cnt  = CNT_W'(c);
    e.lp   = lp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_checks++;
    assert (tick === e.tick) else begin
      n_errors++;
      $error("FAIL %s tick: got %0b expected %0b", tag, tick, e.tick);
    end
    n_checks++;
    assert (aclk === e.aclk) else begin
      n_errors++;
      $error("FAIL %s aclk: got %0b expected %0b", tag, aclk, e.aclk);
    end
    n_checks++;
    assert (busy === e.busy) else begin
      n_errors++;
      $error("FAIL %s busy: got %0b expected %0b", tag, busy, e.busy);
    end
    n_checks++;
    assert (count === e.cnt) else begin
      n_errors++;
      $error("FAIL %s count: got %0d expected %0d", tag, count, e.cnt);
    end
    n_checks++;
    assert (load_pend === e.lp) else begin
      n_errors++;
      $error("FAIL %s load_pend: got %0b expected %0b", tag, load_pend, e.lp);
    end
    $display("step %-14s tick=%0b aclk=%0b busy=%0b count=%0d load_pend=%0b",
             tag, tick, aclk, busy, count, load_pend);
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    mode      = 1'b0;
    start     = 1'b0;
    div_load  = 1'b0;
    div_value = '0;

    // Reset state
    step("rst0", 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0);

    // Free-run, divisor 4: tick every 4 cycles, aclk period 8
    rst  = 1'b0;
    en   = 1'b1;
    mode = 1'b0;
    step("run_enter", 0, 0, 1, 0, 0);
    ea = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 1; c <= 3; c++) step("run_cnt", 0, ea, 1, c, 0);
      ea = ~ea;
      step("run_tick", 1, ea, 1, 0, 0);
    end

    // Pause at count 2 for 3 cycles, then resume
    step("pre_pause", 0, ea, 1, 1, 0);
    step("pre_pause", 0, ea, 1, 2, 0);
    en = 1'b0;
    repeat (3) step("pause", 0, ea, 1, 2, 0);
    en = 1'b1;
    step("resume", 0, ea, 1, 3, 0);
    ea = ~ea;
    step("resume_tick", 1, ea, 1, 0, 0);

    // Reset in the middle of a one-shot at count 2 (aclk currently 1)
    mode = 1'b1;
    step("run_to_idle", 0, 1, 0, 0, 0);
    start = 1'b1;
    step("shot_enter", 0, 1, 1, 0, 0);
    start = 1'b0;
    step("shot_cnt", 0, 1, 1, 1, 0);
    step("shot_cnt", 0, 1, 1, 2, 0);
    rst = 1'b1;
    step("rst_mid_shot", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("idle_post_rst", 0, 0, 0, 0, 0);

    // One-shot: single tick after 4 cycles, start mid-SHOT ignored
    start = 1'b1;
    step("shot_enter", 0, 0, 1, 0, 0);
    start = 1'b0;
    step("shot_cnt", 0, 0, 1, 1, 0);
    start = 1'b1;
    step("shot_restart", 0, 0, 1, 2, 0);
    start = 1'b0;
    step("shot_cnt", 0, 0, 1, 3, 0);
    step("shot_tick", 1, 1, 0, 0, 0);
    step("shot_done", 0, 1, 0, 0, 0);

    // Divisor 0 loaded while IDLE -> behaves as 1
    div_load  = 1'b1;
    div_value = 8'd0;
    step("load0", 0, 1, 0, 0, SYNC_LOAD);
    div_load = 1'b0;
    step("load0_idle", 0, 1, 0, 0, 0);
    mode = 1'b0;
    step("div1_enter", 0, 1, 1, 0, 0);
    ea = 1'b1;
    repeat (4) begin
      ea = ~ea;
      step("div1_tick", 1, ea, 1, 0, 0);
    end

    // Load 6 coincident with a terminal: tick still fires, then period 6
    div_load  = 1'b1;
    div_value = 8'd6;
    ea = ~ea;
    step("load6_term", 1, ea, 1, 0, 0);
    div_load = 1'b0;
    for (int c = 1; c <= 5; c++) step("div6_cnt", 0, ea, 1, c, 0);
    ea = ~ea;
    step("div6_tick", 1, ea, 1, 0, 0);

    // Load 2 at count 1
    step("pre_load2", 0, ea, 1, 1, 0);
    div_load  = 1'b1;
    div_value = 8'd2;
`ifdef DIV_SYNC_LOAD_EN
    step("load2_pend", 0, ea, 1, 2, 1);
    div_load = 1'b0;
    for (int c = 3; c <= 5; c++) step("pend_cnt", 0, ea, 1, c, 1);
    ea = ~ea;
    step("pend_apply", 1, ea, 1, 0, 0);
`else
    step("load2_now", 0, ea, 1, 0, 0);
    div_load = 1'b0;
    step("div2_cnt", 0, ea, 1, 1, 0);
    ea = ~ea;
    step("div2_tick", 1, ea, 1, 0, 0);
`endif
    step("div2_cnt", 0, ea, 1, 1, 0);
    ea = ~ea;
    step("div2_tick", 1, ea, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
